// File: rtl/rtype_issuer.sv
// ==== rtype_issuer: R-type encoder, command FIFO and paced issue FSM (IDLE/PRESENT/GAP) ====
// ==== Optional RTYPE_ISSUER_HAZARD_EN: +2 gap cycles on RAW dependence. Rev 1.0          ====
`default_nettype none

module rtype_issuer #(
  parameter int          DEPTH     = 4,
  parameter int          ISSUE_GAP = 3,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rs1,
  input  logic [4:0]  cmd_rs2,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [31:0] pc,
  output logic [4:0]  fifo_level,
  output logic        err_illegal
);

  localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  C_FULL = 5'(DEPTH);
  localparam logic [4:0]  C_GAP  = 5'(ISSUE_GAP);
  localparam logic [31:0] C_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, GAP = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      count, gap_cnt, gap_len;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            legal, hand, push, pop;
  logic [31:0]     enc, head;

  always_comb begin
    legal  = 1'b1;
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    case (cmd_op)
      4'd0: funct3 = 3'b000;
      4'd1: funct7 = 7'b0100000;
      4'd2: funct3 = 3'b001;
      4'd3: funct3 = 3'b010;
      4'd4: funct3 = 3'b011;
      4'd5: funct3 = 3'b100;
      4'd6: funct3 = 3'b101;
      4'd7: begin funct3 = 3'b101; funct7 = 7'b0100000; end
      4'd8: funct3 = 3'b110;
      4'd9: funct3 = 3'b111;
      default: legal = 1'b0;
    endcase
    enc = {funct7, cmd_rs2, cmd_rs1, funct3, cmd_rd, 7'b0110011};
  end

  assign cmd_ready   = (count != C_FULL);
  assign hand        = cmd_valid && cmd_ready;
  assign push        = hand && legal;
  assign head        = mem[rd_ptr];
  assign instr_valid = (state == PRESENT);
  assign instr       = instr_valid ? head : C_NOP;
  assign pop         = instr_valid && instr_ack;
  assign fifo_level  = count;

`ifdef RTYPE_ISSUER_HAZARD_EN
  logic [4:0] last_rd;
  logic       hazard;

  // The head is re-evaluated every GAP cycle, so a dependent word that arrives mid-gap still stretches it.
  assign hazard  = (count != 5'd0) && (last_rd != 5'd0) &&
                   ((head[19:15] == last_rd) || (head[24:20] == last_rd));
  assign gap_len = hazard ? (C_GAP + 5'd2) : C_GAP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   last_rd <= 5'd0;
    else if (pop) last_rd <= head[11:7];
  end
`else
  assign gap_len = C_GAP;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != 5'd0) state_nxt = PRESENT;
      PRESENT: if (instr_ack) begin
`ifdef RTYPE_ISSUER_HAZARD_EN
        state_nxt = GAP;
`else
        state_nxt = (ISSUE_GAP == 0) ? IDLE : GAP;
`endif
      end
      // A finished gap with work pending goes straight to PRESENT so the idle time equals the gap count.
      GAP:     if (gap_cnt >= gap_len) state_nxt = (count != 5'd0) ? PRESENT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= 5'd0;
      gap_cnt     <= 5'd0;
      pc          <= PC_RESET;
      err_illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        pc     <= pc + 32'd4;
      end
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (pop)                gap_cnt <= 5'd1;
      else if (state == GAP)  gap_cnt <= gap_cnt + 5'd1;
      if (hand && !legal) err_illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

endmodule

`default_nettype wire

// File: tb/tb_rtype_issuer.sv
// Scoreboard bench for rtype_issuer: directed pushes queue hand-computed words, a monitor checks each issue.
`default_nettype none

module tb_rtype_issuer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [4:0]  cmd_rd = 5'd0, cmd_rs1 = 5'd0, cmd_rs2 = 5'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic [31:0] pc;
  logic [4:0]  fifo_level;
  logic        err_illegal;

  rtype_issuer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack), .pc(pc),
    .fifo_level(fifo_level), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } exp_t;
  exp_t        q[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] exp_pc  = 32'd0;
  int          idle_run = 0;
  int          last_gap = -1;
  bit          seen_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted issue is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      idle_run = 0;
      seen_ack = 1'b0;
    end else if (instr_valid) begin
      if (seen_ack) last_gap = idle_run;
      idle_run = 0;
      seen_ack = 1'b0;
      if (instr_ack) begin
        if (q.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("instr", instr, e.instr);
          chk("pc", pc, e.pc);
        end
        seen_ack = 1'b1;
      end
    end else begin
      idle_run++;
    end
  end

  task automatic push(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] exp_i);
    bit done = 1'b0;
    bit rdy;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); rdy = cmd_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
    end
    if (done && op <= 4'd9) begin
      q.push_back('{exp_i, exp_pc});
      exp_pc += 32'd4;
    end
    #1 cmd_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !instr_valid && fifo_level == 5'd0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset values while reset is held low
    #12;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, 32'd0);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk); reset = 1'b1;

    // Single add: visible one cycle after the push edge, held until ack
    push(4'd0, 5'd3, 5'd1, 5'd2, 32'h002081B3);
    @(negedge clk);
    chk("valid_latency0", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("valid_latency1", {31'd0, instr_valid}, 32'd1);
    repeat (3) @(negedge clk);
    chk("hold_instr", instr, 32'h002081B3);
    chk("hold_pc", pc, 32'd0);
    instr_ack = 1'b1;
    wait_idle();

    // sub then xor with ack held high: 3 idle cycles between issues
    last_gap = -1;
    push(4'd1, 5'd5, 5'd1, 5'd2, 32'h402082B3);
    push(4'd5, 5'd7, 5'd4, 5'd6, 32'h006243B3);
    wait_idle();
    chk("issue_gap", 32'(last_gap), 32'd3);

    // Illegal op: handshake only, sticky error
    instr_ack = 1'b0;
    push(4'd12, 5'd1, 5'd1, 5'd1, 32'h0);
    repeat (3) @(negedge clk);
    chk("illegal_err", {31'd0, err_illegal}, 32'd1);
    chk("illegal_level", {27'd0, fifo_level}, 32'd0);
    chk("illegal_valid", {31'd0, instr_valid}, 32'd0);

    // Fill to DEPTH, fifth push waits; pop against full refuses the push that cycle
    push(4'd9, 5'd1, 5'd2, 5'd3, 32'h003170B3);
    push(4'd8, 5'd8, 5'd9, 5'd10, 32'h00A4E433);
    push(4'd2, 5'd31, 5'd31, 5'd1, 32'h001F9FB3);
    push(4'd7, 5'd2, 5'd4, 5'd5, 32'h40525133);
    @(negedge clk);
    chk("full_level", {27'd0, fifo_level}, 32'd4);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    fork
      push(4'd4, 5'd9, 5'd10, 5'd11, 32'h00B534B3);
    join_none
    repeat (3) @(negedge clk);
    chk("held_level", {27'd0, fifo_level}, 32'd4);
    @(posedge clk); #1 instr_ack = 1'b1;
    @(posedge clk); #1 instr_ack = 1'b0;
    @(negedge clk);
    chk("full_ack_level", {27'd0, fifo_level}, 32'd3);
    @(negedge clk);
    chk("refill_level", {27'd0, fifo_level}, 32'd4);
    wait fork;
    instr_ack = 1'b1;
    wait_idle();
    chk("err_sticky", {31'd0, err_illegal}, 32'd1);

`ifdef RTYPE_ISSUER_HAZARD_EN
    last_gap = -1;
    push(4'd0, 5'd3, 5'd1, 5'd2, 32'h002081B3);
    push(4'd8, 5'd4, 5'd3, 5'd0, 32'h0001E233);
    wait_idle();
    chk("hazard_gap", 32'(last_gap), 32'd5);
    last_gap = -1;
    push(4'd0, 5'd0, 5'd1, 5'd2, 32'h00208033);
    push(4'd8, 5'd4, 5'd0, 5'd0, 32'h00006233);
    wait_idle();
    chk("rd0_gap", 32'(last_gap), 32'd3);
`endif

    // Reset during PRESENT with three queued
    instr_ack = 1'b0;
    push(4'd3, 5'd4, 5'd6, 5'd7, 32'h00732233);
    push(4'd6, 5'd6, 5'd7, 5'd8, 32'h0083D333);
    push(4'd0, 5'd3, 5'd1, 5'd2, 32'h002081B3);
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_level", {27'd0, fifo_level}, 32'd0);
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_instr", instr, 32'h0000_0013);
    chk("mid_rst_err", {31'd0, err_illegal}, 32'd0);
    q.delete();
    exp_pc = 32'd0;
    @(negedge clk); reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    instr_ack = 1'b1;
    push(4'd0, 5'd3, 5'd1, 5'd2, 32'h002081B3);
    wait_idle();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
